// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: single-word read bus between the fetch unit and instruction memory
// master (fetch unit): drives mem_rd_en/mem_addr, receives mem_rdata/mem_rvalid
// slave (memory): the mirror image
interface instruction_fetch_unit_if;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  modport master (output mem_rd_en, mem_addr, input mem_rdata, mem_rvalid);
  modport slave (input mem_rd_en, mem_addr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: multicycle fetch sequencer feeding the instruction register
// ports: clk, reset (async, active-high); fetch_req/pc_load/pc_target from control unit;
// imem read bus; instr_data/ir_control to the IR; pc, instr_pc, fetch_done, fetch_fault, busy status
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_req,
  input  logic                      pc_load,
  input  logic [31:0]               pc_target,
  instruction_fetch_unit_if.master  imem,
  output logic [31:0]               instr_data,
  output logic [1:0]                ir_control,
  output logic [31:0]               pc,
  output logic [31:0]               instr_pc,
  output logic                      fetch_done,
  output logic                      fetch_fault,
  output logic                      busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, LATCH, FAULT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] instr_buf;
  logic [1:0] fetch_lsb;
  // a same-cycle redirect supplies the fetch address, so alignment is judged on it
  assign fetch_lsb = pc_load ? pc_target[1:0] : pc[1:0];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = fetch_req ? (fetch_lsb == 2'b00 ? REQ : FAULT) : IDLE;
      REQ:     state_nx = WAIT;
      WAIT:    state_nx = imem.mem_rvalid ? LATCH : (cnt == CW'(TIMEOUT_CYCLES - 1) ? FAULT : WAIT);
      LATCH:   state_nx = IDLE;
      FAULT:   state_nx = pc_load ? IDLE : FAULT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      instr_pc <= '0;
      instr_buf <= '0;
      cnt <= '0;
    end else begin
      if ((state == IDLE || state == FAULT) && pc_load) pc <= pc_target;
      if (state == LATCH) begin
        pc <= pc + 32'd4;
        instr_pc <= pc;
      end
      if (state == REQ) cnt <= '0;
      if (state == WAIT && !imem.mem_rvalid) cnt <= cnt + CW'(1);
      if (state == WAIT && imem.mem_rvalid) instr_buf <= imem.mem_rdata;
    end
  end
  assign imem.mem_rd_en = state == REQ;
  assign imem.mem_addr = state == REQ ? pc : 32'h0;
  assign instr_data = instr_buf;
  // clear bit follows reset combinationally so the IR empties together with the system
  assign ir_control = {reset || state == FAULT, state == LATCH};
  assign fetch_done = state == LATCH;
  assign fetch_fault = state == FAULT;
  assign busy = state == REQ || state == WAIT || state == LATCH;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table plus hand-written corner sequences
module tb_instruction_fetch_unit;
  logic clk = 0;
  logic reset = 1;
  logic fetch_req = 0;
  logic pc_load = 0;
  logic [31:0] pc_target = 0;
  logic [31:0] instr_data, pc, instr_pc;
  logic [1:0] ir_control;
  logic fetch_done, fetch_fault, busy;
  int total = 0;
  int bad = 0;
  instruction_fetch_unit_if bus();
  instruction_fetch_unit #(.RESET_PC(32'h1000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load), .pc_target(pc_target),
    .imem(bus.master), .instr_data(instr_data), .ir_control(ir_control), .pc(pc),
    .instr_pc(instr_pc), .fetch_done(fetch_done), .fetch_fault(fetch_fault), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        load;
    logic [31:0] target;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_ipc;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_fetch(input vec_t v);
    fetch_req = 1;
    pc_load = v.load;
    pc_target = v.target;
    @(negedge clk);
    fetch_req = 0;
    pc_load = 0;
    chk("req_rd_en", 32'(bus.mem_rd_en), 1);
    chk("req_addr", bus.mem_addr, v.exp_addr);
    chk("req_busy", 32'(busy), 1);
    for (int i = 1; i <= v.lat; i++) begin
      @(negedge clk);
      chk("wait_rd_en", 32'(bus.mem_rd_en), 0);
      chk("wait_done", 32'(fetch_done), 0);
      if (i == v.lat) begin
        bus.mem_rvalid = 1;
        bus.mem_rdata = v.rdata;
      end
    end
    @(negedge clk);
    bus.mem_rvalid = 0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    chk("latch_irc", 32'(ir_control), 32'h1);
    chk("latch_data", instr_data, v.rdata);
    chk("latch_done", 32'(fetch_done), 1);
    @(negedge clk);
    chk("after_pc", pc, v.exp_pc);
    chk("after_ipc", instr_pc, v.exp_ipc);
    chk("after_done", 32'(fetch_done), 0);
    chk("after_busy", 32'(busy), 0);
  endtask
  initial begin
    bus.mem_rvalid = 0;
    bus.mem_rdata = 0;
    vecs[0] = '{1'b0, 32'h0,         1, 32'h1111_2222, 32'h1000,      32'h1004,     32'h1000};
    vecs[1] = '{1'b1, 32'h0,         1, 32'h0050_0093, 32'h0,         32'h4,        32'h0};
    vecs[2] = '{1'b0, 32'h0,         2, 32'hA5A5_0F0F, 32'h4,         32'h8,        32'h4};
    vecs[3] = '{1'b1, 32'h100,       3, 32'h0010_0113, 32'h100,       32'h104,      32'h100};
    vecs[4] = '{1'b0, 32'h0,         4, 32'hCAFE_F00D, 32'h104,       32'h108,      32'h104};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFC};
    @(negedge clk);
    chk("rst_pc", pc, 32'h1000);
    chk("rst_irc", 32'(ir_control), 32'h2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
    chk("rst_addr", bus.mem_addr, 0);
    reset = 0;
    @(negedge clk);
    chk("rel_irc", 32'(ir_control), 0);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_fault", 32'(fetch_fault), 0);
    chk("rel_ipc", instr_pc, 0);
    chk("rel_data", instr_data, 0);
    for (int i = 0; i < 6; i++) run_fetch(vecs[i]);
    fetch_req = 1;
    @(negedge clk);
    fetch_req = 0;
    chk("to_req", 32'(bus.mem_rd_en), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_busy", 32'(busy), 1);
      chk("to_wait_fault", 32'(fetch_fault), 0);
    end
    @(negedge clk);
    chk("to_fault", 32'(fetch_fault), 1);
    chk("to_irc", 32'(ir_control), 32'h2);
    chk("to_busy", 32'(busy), 0);
    fetch_req = 1;
    @(negedge clk);
    chk("to_ign_fault", 32'(fetch_fault), 1);
    chk("to_ign_rd_en", 32'(bus.mem_rd_en), 0);
    pc_load = 1;
    pc_target = 32'h200;
    @(negedge clk);
    fetch_req = 0;
    pc_load = 0;
    chk("to_rec_fault", 32'(fetch_fault), 0);
    chk("to_rec_pc", pc, 32'h200);
    chk("to_rec_busy", 32'(busy), 0);
    chk("to_rec_irc", 32'(ir_control), 0);
    pc_load = 1;
    pc_target = 32'h102;
    @(negedge clk);
    pc_load = 0;
    chk("mis_pc", pc, 32'h102);
    fetch_req = 1;
    @(negedge clk);
    fetch_req = 0;
    chk("mis_rd_en", 32'(bus.mem_rd_en), 0);
    chk("mis_fault", 32'(fetch_fault), 1);
    chk("mis_busy", 32'(busy), 0);
    pc_load = 1;
    pc_target = 32'h0;
    @(negedge clk);
    pc_load = 0;
    chk("mis_rec_fault", 32'(fetch_fault), 0);
    fetch_req = 1;
    @(negedge clk);
    fetch_req = 0;
    chk("mid_req", 32'(bus.mem_rd_en), 1);
    @(negedge clk);
    chk("mid_wait", 32'(busy), 1);
    reset = 1;
    #1;
    chk("mid_rst_irc", 32'(ir_control), 32'h2);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pc", pc, 32'h1000);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    bus.mem_rvalid = 1;
    bus.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus.mem_rvalid = 0;
    chk("mid_done", 32'(fetch_done), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_pc", pc, 32'h1000);
    @(negedge clk);
    chk("mid_done2", 32'(fetch_done), 0);
    chk("mid_data", instr_data, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
